// File: rtl/imem_loader_if.sv
// Host-side fields, load control/status and instruction-memory write port of imem_loader.
interface imem_loader_if;
  logic        start;
  logic [15:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [3:0]  in_rd;
  logic [3:0]  in_rs;
  logic [3:0]  in_rt;
  logic [8:0]  in_imm;
  logic [2:0]  in_cond;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] count;

  modport master (
    output start, base_addr, in_valid, in_opcode, in_rd, in_rs, in_rt, in_imm, in_cond,
    input  in_ready, mem_enable, mem_wr, mem_addr, mem_data, busy, done, err, count
  );

  modport slave (
    input  start, base_addr, in_valid, in_opcode, in_rd, in_rs, in_rt, in_imm, in_cond,
    output in_ready, mem_enable, mem_wr, mem_addr, mem_data, busy, done, err, count
  );
endinterface

// File: rtl/imem_loader.sv
// Packs assembled instruction fields into 16-bit ISA words and writes them to
// consecutive instruction-memory addresses until HLT, an illegal field or the word limit.
module imem_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);
  localparam logic [15:0] LP_MAX = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_addr;
  logic [15:0] r_count;
  logic [15:0] r_word;
  logic        r_hlt;
  logic [15:0] w_word;
  logic        w_legal;
  logic        w_xfer;
  logic        w_start_ok;

  assign w_xfer     = bus.in_valid && (r_state == S_ACCEPT);
  assign w_start_ok = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                    (r_state == S_ERROR));

  // Field packing and immediate range checks; fields a format does not use are ignored.
  always_comb begin
    w_word  = {bus.in_opcode, 12'h000};
    w_legal = 1'b1;
    case (bus.in_opcode)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
        w_word = {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_rt};
      end
      4'h4, 4'h5, 4'h6: begin
        w_word  = {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_imm[3:0]};
        w_legal = (bus.in_imm[8:4] == 5'b00000);
      end
      4'h8, 4'h9: begin
        w_word  = {bus.in_opcode, bus.in_rt, bus.in_rs, bus.in_imm[3:0]};
        w_legal = (bus.in_imm[8:3] == 6'h00) || (bus.in_imm[8:3] == 6'h3F);
      end
      4'hA, 4'hB: begin
        w_word  = {bus.in_opcode, bus.in_rd, bus.in_imm[7:0]};
        w_legal = !bus.in_imm[8];
      end
      4'hC: begin
        w_word = {bus.in_opcode, bus.in_cond, bus.in_imm};
      end
      4'hD: begin
        w_word = {bus.in_opcode, bus.in_cond, 1'b0, bus.in_rs, 4'b0000};
      end
      4'hE: begin
        w_word = {bus.in_opcode, bus.in_rd, 8'h00};
      end
      default: begin
        w_word = {bus.in_opcode, 12'h000};
      end
    endcase
  end

  always_comb begin
    w_next_state   = r_state;
    bus.in_ready   = 1'b0;
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = 16'h0000;
    bus.mem_data   = 16'h0000;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.err        = 1'b0;
    bus.count      = r_count;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next_state = S_ACCEPT;
      end
      S_ACCEPT: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (bus.in_valid) w_next_state = w_legal ? S_WRITE : S_ERROR;
      end
      S_WRITE: begin
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = r_addr;
        bus.mem_data   = r_word;
        bus.busy       = 1'b1;
        // HLT wins over the word limit: a halt in the last slot is a clean finish.
        if (r_hlt) begin
          w_next_state = S_DONE;
        end else if (r_count + 16'd1 == LP_MAX) begin
          w_next_state = S_ERROR;
        end else begin
          w_next_state = S_ACCEPT;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        if (bus.start) w_next_state = S_ACCEPT;
      end
      S_ERROR: begin
        bus.err = 1'b1;
        if (bus.start) w_next_state = S_ACCEPT;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= 16'h0000;
      r_count <= 16'h0000;
      r_word  <= 16'h0000;
      r_hlt   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_start_ok) begin
        r_addr  <= bus.base_addr & 16'hFFFE;
        r_count <= 16'h0000;
      end
      if (w_xfer && w_legal) begin
        r_word <= w_word;
        r_hlt  <= (bus.in_opcode == 4'hF);
      end
      if (r_state == S_WRITE) begin
        r_addr  <= r_addr + 16'd2;
        r_count <= r_count + 16'd1;
      end
    end
  end
endmodule
